// File: rtl/ram_arbiter_pkg.sv
// Shared types and sizes for the RAM arbiter/sequencer and its round-robin grant logic.
package ram_arbiter_pkg;

    localparam int RAM_AW    = 8;
    localparam int RAM_DW    = 16;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic {IDLE, CLEAR} state_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two request channels plus shared read data.
// Handshake: req_x/we_x/addr_x/wdata_x are held stable until gnt_x; the access is accepted in the cycle gnt_x is high.
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          req_a, req_b;
    logic          we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b;
    logic          rvalid_a, rvalid_b;
    logic [DW-1:0] rdata;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the side not granted last.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    req_id_t last_gnt;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && (!req_b || last_gnt == REQ_B)) gnt_a = 1'b1;
            else if (req_b)                             gnt_b = 1'b1;
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_gnt <= REQ_B;
        else if (gnt_a) last_gnt <= REQ_A;
        else if (gnt_b) last_gnt <= REQ_B;
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and clear sequencer owning the command port of a single-port sync RAM.
// Optional grant counters are enabled with `define RAM_ARB_STATS_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int          AW      = RAM_AW,
    parameter int          DW      = RAM_DW,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          sysclk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
`ifdef RAM_ARB_STATS_EN
    output logic [15:0]   gnt_cnt_a,
    output logic [15:0]   gnt_cnt_b,
`endif
    output state_t        dbg_state
);
    state_t        state, state_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic          arb_en, sweep_start;
    logic          gnt_a, gnt_b;
    logic          rd_v1, rd_v2;
    req_id_t       rd_t1, rd_t2;

    rr_arb2 u_arb (
        .clk   (sysclk),
        .rst_n (reset_n),
        .en    (arb_en),
        .req_a (bus.req_a),
        .req_b (bus.req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // cnt MSB flags the end of the sweep, so the last address never aliases to 0.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sweep_start = 1'b0;
        arb_en      = 1'b0;
        clr_busy    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt   = CLEAR;
                    cnt_nxt     = '0;
                    sweep_start = 1'b1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                if (cnt_nxt[AW]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_done <= (state == CLEAR) && (state_nxt == IDLE);
        end
    end

    // Command register: the RAM sees the granted access one cycle after the grant.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else if (state == CLEAR) begin
            ram_write <= 1'b1;
            ram_addr  <= cnt[AW-1:0];
            ram_din   <= CLR_VAL;
        end else if (gnt_a) begin
            ram_write <= bus.we_a;
            ram_addr  <= bus.addr_a;
            ram_din   <= bus.wdata_a;
        end else if (gnt_b) begin
            ram_write <= bus.we_b;
            ram_addr  <= bus.addr_b;
            ram_din   <= bus.wdata_b;
        end else begin
            ram_write <= 1'b0;
        end
    end

    // Requester tag follows a read through command and RAM output stages.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1 <= 1'b0;
            rd_v2 <= 1'b0;
            rd_t1 <= REQ_A;
            rd_t2 <= REQ_A;
        end else begin
            rd_v1 <= (gnt_a && !bus.we_a) || (gnt_b && !bus.we_b);
            rd_t1 <= gnt_b ? REQ_B : REQ_A;
            rd_v2 <= rd_v1;
            rd_t2 <= rd_t1;
        end
    end

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.rvalid_a = rd_v2 && (rd_t2 == REQ_A);
    assign bus.rvalid_b = rd_v2 && (rd_t2 == REQ_B);
    assign bus.rdata    = ram_dout;
    assign dbg_state    = state;

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n || sweep_start) begin
            gnt_cnt_a <= '0;
            gnt_cnt_b <= '0;
        end else begin
            if (gnt_a && gnt_cnt_a != 16'hFFFF) gnt_cnt_a <= gnt_cnt_a + 16'd1;
            if (gnt_b && gnt_cnt_b != 16'hFFFF) gnt_cnt_b <= gnt_cnt_b + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic against a transaction-order RAM model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = RAM_AW;
    localparam int DW = RAM_DW;
    localparam int DEPTH = RAM_DEPTH;

    // ---------------- clock / reset / DUT ----------------
    logic          sysclk = 1'b0;
    logic          reset_n;
    logic          clr_start;
    logic          clr_busy, clr_done, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    state_t        dbg_state;
`ifdef RAM_ARB_STATS_EN
    logic [15:0]   gnt_cnt_a, gnt_cnt_b;
`endif

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
`ifdef RAM_ARB_STATS_EN
        .gnt_cnt_a (gnt_cnt_a),
        .gnt_cnt_b (gnt_cnt_b),
`endif
        .dbg_state (dbg_state)
    );

    always #5 sysclk = ~sysclk;

    // Behavioural 256x16 RAM with a bench-side preload port.
    logic [DW-1:0] mem [DEPTH];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    always @(posedge sysclk) begin
        if (ld_en)          mem[ld_addr] <= ld_data;
        else if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    int            tests_run = 0, tests_failed = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            tag_q[$];
    int            due_q[$];
    int            sweep_left, last_w, st_a, st_b;
    bit            done_flag;
    int            cmd_kind;          // 0 none, 1 read, 2 write
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_din;
    int            cmd_tag;
    bit            p_req_a, p_req_b, p_we_a, p_we_b, p_clr;
    logic [AW-1:0] p_addr_a, p_addr_b;
    logic [DW-1:0] p_wdata_a, p_wdata_b;
    bit            obs_a;
    int            busy_cycles, sweep_grants;
    logic [DW-1:0] last_rdata_a;

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        bus.req_a   = p_req_a;   bus.req_b   = p_req_b;
        bus.we_a    = p_we_a;    bus.we_b    = p_we_b;
        bus.addr_a  = p_addr_a;  bus.addr_b  = p_addr_b;
        bus.wdata_a = p_wdata_a; bus.wdata_b = p_wdata_b;
        clr_start   = p_clr;
    endtask

    task automatic set_a(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req_a = 1'b1; p_we_a = we; p_addr_a = a; p_wdata_a = d;
    endtask

    task automatic set_b(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req_b = 1'b1; p_we_b = we; p_addr_b = a; p_wdata_b = d;
    endtask

    // One clock: drive, check at negedge against the model, advance the model, then the edge.
    task automatic step();
        bit eg_a, eg_b, nxt_done;
        int t;
        logic [DW-1:0] d;
        drive();
        @(negedge sysclk);
        eg_a = 1'b0;
        eg_b = 1'b0;
        if (sweep_left == 0 && !p_clr) begin
            if (p_req_a && p_req_b) begin
                eg_a = (last_w == 1);
                eg_b = !eg_a;
            end else begin
                eg_a = p_req_a;
                eg_b = p_req_b;
            end
        end
        obs_a = bus.gnt_a;
        check_eq("gnt_a", 32'(bus.gnt_a), 32'(eg_a));
        check_eq("gnt_b", 32'(bus.gnt_b), 32'(eg_b));
        check_eq("clr_busy", 32'(clr_busy), 32'(sweep_left > 0));
        check_eq("clr_done", 32'(clr_done), 32'(done_flag));
        if (clr_busy) begin
            busy_cycles++;
            if (bus.gnt_a || bus.gnt_b) sweep_grants++;
        end
        check_eq("ram_write", 32'(ram_write), 32'(cmd_kind == 2));
        if (cmd_kind != 0) check_eq("ram_addr", 32'(ram_addr), 32'(cmd_addr));
        if (cmd_kind == 2) check_eq("ram_din", 32'(ram_din), 32'(cmd_din));
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            t = tag_q.pop_front();
            void'(due_q.pop_front());
            d = exp_q.pop_front();
            check_eq("rvalid_a", 32'(bus.rvalid_a), 32'(t == 0));
            check_eq("rvalid_b", 32'(bus.rvalid_b), 32'(t == 1));
            check_eq("rdata", 32'(bus.rdata), 32'(d));
        end else begin
            check_eq("rvalid_a_idle", 32'(bus.rvalid_a), 32'd0);
            check_eq("rvalid_b_idle", 32'(bus.rvalid_b), 32'd0);
        end
        if (bus.rvalid_a) last_rdata_a = bus.rdata;
`ifdef RAM_ARB_STATS_EN
        check_eq("gnt_cnt_a", 32'(gnt_cnt_a), 32'(st_a));
        check_eq("gnt_cnt_b", 32'(gnt_cnt_b), 32'(st_b));
`endif
        // The command visible this cycle is what the RAM performs at the coming edge.
        if (cmd_kind == 2) ref_mem[cmd_addr] = cmd_din;
        else if (cmd_kind == 1) begin
            exp_q.push_back(ref_mem[cmd_addr]);
            tag_q.push_back(cmd_tag);
            due_q.push_back(cyc + 1);
        end
        nxt_done = 1'b0;
        if (sweep_left > 0) begin
            cmd_kind = 2;
            cmd_addr = AW'(DEPTH - sweep_left);
            cmd_din  = '0;
            sweep_left--;
            nxt_done = (sweep_left == 0);
        end else if (p_clr) begin
            cmd_kind = 0;
            sweep_left = DEPTH;
            st_a = 0;
            st_b = 0;
        end else if (eg_a) begin
            cmd_kind = p_we_a ? 2 : 1;
            cmd_addr = p_addr_a; cmd_din = p_wdata_a; cmd_tag = 0;
            last_w = 0;
            if (st_a < 65535) st_a++;
            p_req_a = 1'b0;
        end else if (eg_b) begin
            cmd_kind = p_we_b ? 2 : 1;
            cmd_addr = p_addr_b; cmd_din = p_wdata_b; cmd_tag = 1;
            last_w = 1;
            if (st_b < 65535) st_b++;
            p_req_b = 1'b0;
        end else begin
            cmd_kind = 0;
        end
        done_flag = nxt_done;
        p_clr = 1'b0;
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        p_req_a = 1'b0; p_req_b = 1'b0; p_clr = 1'b0;
        drive();
        sweep_left = 0; done_flag = 1'b0; last_w = 1; cmd_kind = 0;
        st_a = 0; st_b = 0;
        exp_q.delete(); tag_q.delete(); due_q.delete();
        #1;
        check_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
        check_eq("rst_clr_done", 32'(clr_done), 32'd0);
        check_eq("rst_ram_write", 32'(ram_write), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_ram_din", 32'(ram_din), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        check_eq("rst_rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'd0);
        repeat (2) @(posedge sysclk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic finish_sweep();
        for (int i = 0; i < 300 && sweep_left > 0; i++) step();
        check_eq("sweep_bound", 32'(sweep_left), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] seq;
        int guard;
        reset_n = 1'b0;
        p_req_a = 0; p_req_b = 0; p_we_a = 0; p_we_b = 0; p_clr = 0;
        p_addr_a = '0; p_addr_b = '0; p_wdata_a = '0; p_wdata_b = '0;
        drive();
        for (int i = 0; i < DEPTH; i++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_data = (i == 16'h10) ? 16'hBEEF : DW'($urandom);
            ref_mem[i] = ld_data;
            @(posedge sysclk);
            #1;
        end
        ld_en = 1'b0;
        apply_reset();

        // Lone read of preloaded 0x10 via A.
        set_a(1'b0, 8'h10, '0);
        step();
        idle(3);
        check_eq("t1_rdata", 32'(last_rdata_a), 32'hBEEF);

        // Held dual requests alternate starting with A after reset.
        apply_reset();
        seq = '0;
        for (int k = 0; k < 6; k++) begin
            if (!p_req_a) set_a(1'b0, AW'($urandom_range(0, 255)), '0);
            if (!p_req_b) set_b(1'b0, AW'($urandom_range(0, 255)), '0);
            step();
            seq = {seq[4:0], obs_a};
        end
        check_eq("t2_alt_seq", 32'(seq), 32'b101010);
        idle(3);

        // Write via B then read-back via A on the next cycle.
        set_b(1'b1, 8'h05, 16'h1234);
        step();
        set_a(1'b0, 8'h05, '0);
        step();
        idle(3);
        check_eq("t3_raw", 32'(last_rdata_a), 32'h1234);

        // Sweep with a pending request; clr_start mid-sweep is ignored.
        set_a(1'b0, 8'h7F, '0);
        p_clr = 1'b1;
        busy_cycles = 0;
        sweep_grants = 0;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 100) p_clr = 1'b1;
            step();
        end
        check_eq("t4_busy_cycles", 32'(busy_cycles), 32'(DEPTH));
        check_eq("t4_sweep_grants", 32'(sweep_grants), 32'd0);
        step();
        set_a(1'b0, 8'h00, '0);
        set_b(1'b0, 8'hFF, '0);
        idle(5);
        check_eq("t4_rdata_7f_00", 32'(last_rdata_a), 32'd0);

        // Repopulate a few words, then reset partway through a sweep.
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, AW'(8'h3E + i), DW'($urandom));
            set_b(1'b1, AW'(8'hF0 + i), DW'($urandom));
            idle(2);
        end
        set_a(1'b1, 8'hFF, 16'hA5A5);
        idle(2);
        p_clr = 1'b1;
        step();
        guard = 0;
        while (!(cmd_kind == 2 && cmd_addr == 8'h41) && guard < 300) begin
            step();
            guard++;
        end
        check_eq("t5_reach_41", 32'(guard < 300), 32'd1);
        apply_reset();
        set_a(1'b0, 8'h40, '0);
        set_b(1'b0, 8'h41, '0);
        step();
        set_a(1'b0, 8'hFF, '0);
        idle(4);
        check_eq("t5_ff_kept", 32'(last_rdata_a), 32'hA5A5);

`ifdef RAM_ARB_STATS_EN
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, AW'(i), DW'(i));
            if (i < 2) set_b(1'b1, AW'(8'h20 + i), DW'(i));
            idle(2);
        end
        idle(2);
        check_eq("stats_a", 32'(gnt_cnt_a), 32'd3);
        check_eq("stats_b", 32'(gnt_cnt_b), 32'd2);
        p_clr = 1'b1;
        step();
        check_eq("stats_clr_a", 32'(gnt_cnt_a), 32'd0);
        check_eq("stats_clr_b", 32'(gnt_cnt_b), 32'd0);
        finish_sweep();
`endif

        // Random traffic over a narrow address window to hit read-after-write often.
        for (int k = 0; k < 700; k++) begin
            if (!p_req_a && $urandom_range(0, 2) != 0)
                set_a(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            if (!p_req_b && $urandom_range(0, 2) != 0)
                set_b(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            if ($urandom_range(0, 299) == 0) p_clr = 1'b1;
            step();
        end

        // Drain and compare the whole array against the model.
        finish_sweep();
        for (int i = 0; i < 8 && (p_req_a || p_req_b); i++) step();
        idle(4);
        check_eq("drain_q", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) check_eq("mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
